// File: rtl/complex_matrix_serializer.sv
// complex_matrix_serializer: takes one whole complex matrix per beat and re-emits it one element per beat
// in row-major or column-major order, with start/end/row-end flags.
module complex_matrix_serializer #(
    parameter int MAT_WIDTH    = 4,
    parameter int MAT_HEIGHT   = 4,
    parameter int ELEMENT_SIZE = 32,
    parameter int COL_MAJOR    = 0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0]  s_axis_tdata,
    input  logic                                          s_axis_tvalid,
    output logic                                          s_axis_tready,
    output logic [ELEMENT_SIZE-1:0]                       m_axis_tdata,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tlast,
    output logic                                          m_axis_tuser,
    output logic                                          row_last,
    output logic                                          busy
);
    localparam int N = MAT_WIDTH * MAT_HEIGHT;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] I_MAX = IW'(COL_MAJOR != 0 ? MAT_HEIGHT - 1 : MAT_WIDTH - 1);
    localparam logic [IW-1:0] O_MAX = IW'(COL_MAJOR != 0 ? MAT_WIDTH - 1 : MAT_HEIGHT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state;
    logic [N*ELEMENT_SIZE-1:0]     hold;
    logic [IW-1:0]                 idx, o, i, elem;
    logic                          send, load, fire;

    assign send = (state == SEND);
    // In SEND a new matrix is only taken while the last element is being handed off.
    assign s_axis_tready = !send || (idx == LAST && m_axis_tready);
    assign load = s_axis_tvalid && s_axis_tready;
    assign fire = send && m_axis_tready;
    assign elem = COL_MAJOR != 0 ? IW'(i * MAT_WIDTH + o) : IW'(o * MAT_WIDTH + i);

    assign m_axis_tvalid = send;
    assign m_axis_tdata  = send ? hold[elem*ELEMENT_SIZE +: ELEMENT_SIZE] : '0;
    assign m_axis_tuser  = send && idx == '0;
    assign m_axis_tlast  = send && idx == LAST;
    assign row_last      = send && i == I_MAX;
    assign busy          = send;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
            idx   <= '0;
            o     <= '0;
            i     <= '0;
        end else if (load) begin
            state <= SEND;
            hold  <= s_axis_tdata;
            idx   <= '0;
            o     <= '0;
            i     <= '0;
        end else if (fire) begin
            state <= idx == LAST ? IDLE : SEND;
            idx   <= idx == LAST ? '0 : idx + 1'b1;
            i     <= i == I_MAX ? '0 : i + 1'b1;
            o     <= i != I_MAX ? o : (o == O_MAX ? '0 : o + 1'b1);
        end
    end
endmodule

// File: tb/tb_complex_matrix_serializer.sv
// tb_complex_matrix_serializer: directed checks of a row-major and a column-major serializer
// driven by the same stimulus.
module tb_complex_matrix_serializer;
    logic         clk = 0;
    logic         reset;
    logic [511:0] s_tdata;
    logic         s_tvalid, m_tready;
    logic         s_tready_r, s_tready_c;
    logic [31:0]  tdata_r, tdata_c;
    logic         tvalid_r, tvalid_c, tlast_r, tlast_c, tuser_r, tuser_c;
    logic         rlast_r, rlast_c, busy_r, busy_c;
    logic [511:0] ma, mb, mc;
    int           compared = 0;
    int           mismatched = 0;
    int           cnt;

    always #5 clk = ~clk;

    complex_matrix_serializer #(.COL_MAJOR(0)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_r),
        .m_axis_tdata(tdata_r), .m_axis_tvalid(tvalid_r), .m_axis_tready(m_tready),
        .m_axis_tlast(tlast_r), .m_axis_tuser(tuser_r), .row_last(rlast_r), .busy(busy_r));

    complex_matrix_serializer #(.COL_MAJOR(1)) dut_c (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_c),
        .m_axis_tdata(tdata_c), .m_axis_tvalid(tvalid_c), .m_axis_tready(m_tready),
        .m_axis_tlast(tlast_c), .m_axis_tuser(tuser_c), .row_last(rlast_c), .busy(busy_c));

    function automatic logic [31:0] ea(int k);
        return {16'(k), 16'(-k)};
    endfunction

    function automatic logic [31:0] eb(int k);
        return {16'(k + 100), 16'(3 * k)};
    endfunction

    function automatic int col(int k);
        return (k % 4) * 4 + k / 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [511:0] m);
        s_tdata  = m;
        s_tvalid = 1;
        tick();
        s_tvalid = 0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            ma[k*32 +: 32] = ea(k);
            mb[k*32 +: 32] = eb(k);
            mc[k*32 +: 32] = 32'h0004_0006;
        end
        reset = 1; s_tvalid = 0; m_tready = 0; s_tdata = '0;
        tick(); tick();
        chk("rst_tvalid", {31'd0, tvalid_r}, 0);
        chk("rst_busy", {31'd0, busy_r}, 0);
        chk("rst_sready", {31'd0, s_tready_r}, 1);
        chk("rst_tlast", {31'd0, tlast_r}, 0);
        chk("rst_tuser", {31'd0, tuser_r}, 0);
        chk("rst_tdata", tdata_r, 0);
        @(negedge clk); reset = 0;
        tick();

        // row-major and column-major full-rate stream
        m_tready = 1;
        load(ma);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("row_data%0d", k), tdata_r, ea(k));
            chk($sformatf("row_tuser%0d", k), {31'd0, tuser_r}, {31'd0, k == 0});
            chk($sformatf("row_tlast%0d", k), {31'd0, tlast_r}, {31'd0, k == 15});
            chk($sformatf("row_rlast%0d", k), {31'd0, rlast_r}, {31'd0, k % 4 == 3});
            chk($sformatf("row_sready%0d", k), {31'd0, s_tready_r}, {31'd0, k == 15});
            chk($sformatf("col_data%0d", k), tdata_c, ea(col(k)));
            chk($sformatf("col_rlast%0d", k), {31'd0, rlast_c}, {31'd0, k % 4 == 3});
            chk($sformatf("col_tlast%0d", k), {31'd0, tlast_c}, {31'd0, k == 15});
            tick();
        end
        chk("row_end_busy", {31'd0, busy_r}, 0);
        chk("col_end_busy", {31'd0, busy_c}, 0);
        chk("row_end_tvalid", {31'd0, tvalid_r}, 0);

        // asynchronous reset in the middle of a matrix
        load(ma);
        for (int k = 0; k < 7; k++) tick();
        chk("pre_rst_data", tdata_r, ea(7));
        #2 reset = 1;
        #1;
        chk("mid_rst_tvalid", {31'd0, tvalid_r}, 0);
        chk("mid_rst_busy", {31'd0, busy_r}, 0);
        chk("mid_rst_sready", {31'd0, s_tready_r}, 1);
        chk("mid_rst_tlast", {31'd0, tlast_r}, 0);
        @(negedge clk); reset = 0;
        tick();
        load(ma);
        chk("post_rst_tuser", {31'd0, tuser_r}, 1);
        chk("post_rst_data", tdata_r, ea(0));
        for (int k = 0; k < 16; k++) tick();
        chk("post_rst_busy", {31'd0, busy_r}, 0);

        // random backpressure
        load(ma);
        cnt = 0;
        for (int c = 0; c < 300 && cnt < 16; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            chk($sformatf("bp_tvalid_c%0d", c), {31'd0, tvalid_r}, 1);
            chk($sformatf("bp_row_data_c%0d", c), tdata_r, ea(cnt));
            chk($sformatf("bp_col_data_c%0d", c), tdata_c, ea(col(cnt)));
            chk($sformatf("bp_tlast_c%0d", c), {31'd0, tlast_r}, {31'd0, cnt == 15});
            if (m_tready) cnt++;
            tick();
        end
        chk("bp_handshakes", cnt, 16);
        chk("bp_end_busy", {31'd0, busy_r}, 0);

        // back-to-back matrices A then B with upstream valid held
        m_tready = 1;
        s_tdata  = ma;
        s_tvalid = 1;
        tick();
        s_tdata = mb;
        for (int c = 0; c < 32; c++) begin
            if (c >= 16) s_tvalid = 0;
            chk($sformatf("b2b_data%0d", c), tdata_r, c < 16 ? ea(c) : eb(c - 16));
            chk($sformatf("b2b_tvalid%0d", c), {31'd0, tvalid_r}, 1);
            chk($sformatf("b2b_sready%0d", c), {31'd0, s_tready_r}, {31'd0, c == 15 || c == 31});
            chk($sformatf("b2b_tuser%0d", c), {31'd0, tuser_r}, {31'd0, c == 0 || c == 16});
            chk($sformatf("b2b_tlast%0d", c), {31'd0, tlast_r}, {31'd0, c == 15 || c == 31});
            tick();
        end
        chk("b2b_end_busy", {31'd0, busy_r}, 0);

        // output of an adder summing all-0x0001_0002 and all-0x0003_0004
        load(mc);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("add_data%0d", k), tdata_r, 32'h0004_0006);
            chk($sformatf("add_col_data%0d", k), tdata_c, 32'h0004_0006);
            tick();
        end
        chk("add_end_busy", {31'd0, busy_r}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
